wavlet_post: RTL and testbench
==============================

# wavlet_post

Post-processing stage directly downstream of the two-band wavelet analysis filter. It takes the 21-bit signed high-band (detail, hd) and low-band (approximation, ld) coefficient pair produced each output cycle and thresholds the detail coefficient. It then rounds and saturates both coefficients to 16 bits and buffers the pairs in a FIFO with a valid/ready handshake to the consumer. The filter cannot stall, so when the FIFO is full the block drops the pair and counts it rather than back-pressuring.

## Interface
- SHIFT, 4: right-shift applied to both coefficients before saturation; 1..8.
- DEPTH, 8: FIFO entries; power of two, 2..64.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  hd_in/ld_in/thr carry a new coefficient pair this cycle.
- hd_in  in  21  signed detail coefficient.
- ld_in  in  21  signed approximation coefficient.
- thr  in  20  unsigned threshold magnitude, sampled with the pair.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts head this cycle.
- out_hd  out  16  signed processed detail at FIFO head.
- out_ld  out  16  signed processed approximation at FIFO head.
- level  out  $clog2(DEPTH)+1  current FIFO occupancy.
- drop_cnt  out  16  pairs dropped on full FIFO; saturates at 65535.
- ovf  out  1  sticky; set on the first drop.

## Operation
- Stage 1, registered on in_valid:
  - hd, ld, thr and a valid bit.
  - abs_hd = |hd| as 21-bit unsigned; |−2^20| = 2^20 is representable.
- Stage 2, threshold on hd:
  - abs_hd <= thr gives t = 0.
  - Otherwise the hard-threshold result is t = hd.
  - See Configuration for the soft variant.
  - ld passes unchanged.
- Stage 2, round and saturate (both channels):
  - Compute y = (x + 2^(SHIFT−1)) >>> SHIFT in 22-bit signed arithmetic (round half toward +inf).
  - Clamp y to [−32768, 32767].
  - The result is registered with its valid bit.
- FIFO write:
  - A valid stage-2 result is written when level < DEPTH, or when a pop occurs in the same cycle.
  - Otherwise the pair is dropped: drop_cnt increments (saturating) and ovf is set.
- FIFO read:
  - Show-ahead: out_hd/out_ld always present the head while out_valid = (level != 0).
  - A pop occurs when out_valid && out_ready.
  - out_ready while empty has no effect.
- Pointers wrap modulo DEPTH. level changes by +1 on push only, −1 on pop only, and 0 on both.
- Ordering is strictly preserved. Stages 1 and 2 never stall.
- Reset: clears pipeline valid bits, pointers, level, drop_cnt and ovf. A pair presented in the reset cycle is discarded.

## Timing
- Reset values: out_valid=0, level=0, drop_cnt=0, ovf=0, out_hd=0, out_ld=0.
- Latency:
  - A pair with in_valid high at edge E0 is in stage 1 after E0, in stage 2 after E1, and written at E2.
  - With the FIFO empty, out_valid rises in the cycle after E2 (3 cycles).
- Throughput: one pair per cycle sustained when out_ready is held high.
- Full + simultaneous pop: the pop and push both take effect at the same edge; level stays at DEPTH, nothing is dropped.
- A pop at edge E takes effect on out_valid/level/head in the cycle after E.
- Reset mid-stream takes effect at the edge where rst is sampled high. Outputs hold their reset values from the next cycle until new data propagates (3 cycles after rst falls and in_valid rises).

## Configuration
- WAVLET_THR_SOFT_EN defined selects soft thresholding: abs_hd > thr gives t = sign(hd)·(abs_hd − thr).
- WAVLET_THR_SOFT_EN undefined selects hard thresholding: t = hd.
- The zeroing rule (abs_hd <= thr gives 0), latency and all other behaviour are identical in both builds.

## Test plan
All scenarios use SHIFT=4 and DEPTH=8.
- Threshold: hd=1000, thr=500, ld=25600, out_ready=1.
  - Hard build: out_hd=63, out_ld=1600, 3 cycles after input.
  - Soft build: out_hd=31.
- Dead zone and rounding: hd=−300, thr=300 gives out_hd=0 in both builds. ld=−24 gives −1; ld=−8 gives 0.
- Saturation: ld=1048575 gives out_ld=32767; ld=−1048576 gives −32768. hd with thr=0 gives the same clamps.
- Overflow: out_ready=0, 10 consecutive pairs with ld=1..10 (×16) gives level=8, drop_cnt=2, ovf=1. Then out_ready=1 gives out_ld 1..8 in order, and ovf stays 1.
- Full with simultaneous push/pop: FIFO full, out_ready=1, pairs streaming gives drop_cnt unchanged, level holds 8, and the output order is continuous.
- Reset mid-operation: rst high for 1 cycle with level=5 and 2 pairs in flight gives out_valid=0, level=0, drop_cnt=0, ovf=0 next cycle. The in-flight pairs never appear, and the next pair emerges 3 cycles after its input.

Source files
------------

// File: rtl/wavlet_post.sv
// Thresholds, rounds and saturates the wavelet detail/approximation pair, then buffers it for the consumer.
// Latency: 3 cycles from in_valid to out_valid on an empty FIFO, one pair per cycle sustained.
// Backpressure: none upstream (the filter cannot stall); pairs arriving at a full FIFO are dropped and counted.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   in_valid, hd_in, ld_in, thr
//                       input pair (21-bit signed) and 20-bit unsigned threshold
//   out_valid, out_ready, out_hd, out_ld
//                       show-ahead FIFO head (16-bit signed) with valid/ready handshake
//   level               FIFO occupancy
//   drop_cnt, ovf       saturating drop counter and sticky overflow flag
//
// Build option: define WAVLET_THR_SOFT_EN for soft thresholding (shrink by thr);
// leave it undefined for hard thresholding (keep hd as-is above thr).

module wavlet_post #(
    parameter int SHIFT = 4,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic signed [20:0]         hd_in,
    input  logic signed [20:0]         ld_in,
    input  logic [19:0]                thr,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [15:0]         out_hd,
    output logic signed [15:0]         out_ld,
    output logic [$clog2(DEPTH):0]     level,
    output logic [15:0]                drop_cnt,
    output logic                       ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0]     FULL_LVL = LW'(DEPTH);
    localparam logic signed [21:0] RND     = 22'sd1 <<< (SHIFT - 1);
    localparam logic signed [21:0] SAT_MAX = 22'sd32767;
    localparam logic signed [21:0] SAT_MIN = -22'sd32768;

    typedef struct packed {
        logic signed [15:0] hd;
        logic signed [15:0] ld;
    } pair_t;

    // Round half toward +inf, then clamp to the 16-bit signed range.
    function automatic logic signed [15:0] round_sat(input logic signed [21:0] x);
        logic signed [21:0] y;
        y = (x + RND) >>> SHIFT;
        if (y > SAT_MAX) begin
            return 16'sh7fff;
        end else if (y < SAT_MIN) begin
            return 16'sh8000;
        end else begin
            return y[15:0];
        end
    endfunction

    // ------------------------------------------------------------------
    // Stage 1: capture the pair and precompute |hd|
    // ------------------------------------------------------------------
    logic               s1_vld;
    logic signed [20:0] s1_hd;
    logic signed [20:0] s1_ld;
    logic [19:0]        s1_thr;
    logic [20:0]        s1_abs;
    logic [20:0]        abs_in;

    // 21 unsigned bits hold |-2^20| = 2^20 exactly.
    always_comb begin
        abs_in = hd_in[20] ? 21'(-hd_in) : hd_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld <= 1'b0;
        end else begin
            s1_vld <= in_valid;
        end
        if (in_valid) begin
            s1_hd  <= hd_in;
            s1_ld  <= ld_in;
            s1_thr <= thr;
            s1_abs <= abs_in;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: threshold the detail channel, round/saturate both channels
    // ------------------------------------------------------------------
    logic signed [21:0] thr_res;
`ifdef WAVLET_THR_SOFT_EN
    logic [20:0]        mag;
`endif

    always_comb begin
        thr_res = '0;
`ifdef WAVLET_THR_SOFT_EN
        mag = s1_abs - {1'b0, s1_thr};
`endif
        if (s1_abs > {1'b0, s1_thr}) begin
`ifdef WAVLET_THR_SOFT_EN
            thr_res = s1_hd[20] ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
`else
            thr_res = {s1_hd[20], s1_hd};
`endif
        end
    end

    logic  s2_vld;
    pair_t s2_dat;

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_vld <= 1'b0;
        end else begin
            s2_vld <= s1_vld;
        end
        if (s1_vld) begin
            s2_dat.hd <= round_sat(thr_res);
            s2_dat.ld <= round_sat({s1_ld[20], s1_ld});
        end
    end

    // ------------------------------------------------------------------
    // Show-ahead FIFO. A full FIFO still accepts a push when the head is
    // popped at the same edge, so a streaming consumer never causes drops.
    // ------------------------------------------------------------------
    pair_t          mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [LW-1:0]  cnt;
    logic           fifo_full;
    logic           pop;
    logic           wr_rdy;
    logic           push;
    logic           drop;
    pair_t          head;

    always_comb begin
        out_valid = (cnt != '0);
        fifo_full = (cnt == FULL_LVL);
        pop       = out_valid && out_ready;
        wr_rdy    = !fifo_full || pop;
        push      = s2_vld && wr_rdy;
        drop      = s2_vld && !wr_rdy;
        head      = mem[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= s2_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Head storage is not reset, so force zeros while the FIFO is empty.
    assign out_hd = out_valid ? head.hd : '0;
    assign out_ld = out_valid ? head.ld : '0;
    assign level  = cnt;

    // ------------------------------------------------------------------
    // Drop accounting
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= '0;
            ovf      <= 1'b0;
        end else if (drop) begin
            if (drop_cnt != 16'hffff) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
            ovf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_wavlet_post.sv
module tb_wavlet_post;

    localparam int SHIFT = 4;
    localparam int DEPTH = 8;

`ifdef WAVLET_THR_SOFT_EN
    localparam int EXP_P1000 = 31;
    localparam int EXP_N1000 = -31;
    localparam int EXP_17    = 0;
    localparam int EXP_301   = 0;
    localparam int EXP_EDGE  = 0;
`else
    localparam int EXP_P1000 = 63;
    localparam int EXP_N1000 = -62;
    localparam int EXP_17    = 1;
    localparam int EXP_301   = 19;
    localparam int EXP_EDGE  = -32768;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic [20:0]        hd_in;
    logic [20:0]        ld_in;
    logic [19:0]        thr;
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] out_hd;
    logic signed [15:0] out_ld;
    logic [3:0]         level;
    logic [15:0]        drop_cnt;
    logic               ovf;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int hd;
        int ld;
    } exp_t;

    exp_t exp_q[$];

    wavlet_post #(.SHIFT(SHIFT), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .hd_in     (hd_in),
        .ld_in     (ld_in),
        .thr       (thr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_hd    (out_hd),
        .out_ld    (out_ld),
        .level     (level),
        .drop_cnt  (drop_cnt),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int h, input int l, input int t,
                        input int eh, input int el, input bit keep);
        exp_t e;
        in_valid = 1'b1;
        hd_in    = 21'(h);
        ld_in    = 21'(l);
        thr      = 20'(t);
        if (keep) begin
            e.hd = eh;
            e.ld = el;
            exp_q.push_back(e);
        end
        step();
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) begin
            step();
        end
        step();
        check({tag, "_pending"}, 32'(exp_q.size()), 0);
        check({tag, "_out_valid"}, 32'(out_valid), 0);
    endtask

    // Scoreboard: a pop happens at the next rising edge whenever the head is
    // valid and ready is high, so compare the head against the oldest entry.
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out_valid", 32'(out_valid), 0);
            end else begin
                e = exp_q.pop_front();
                check("sb_out_hd", 32'(out_hd), e.hd);
                check("sb_out_ld", 32'(out_ld), e.ld);
            end
        end
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        hd_in     = '0;
        ld_in     = '0;
        thr       = '0;
        step();
        step();

        // Reset values
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_level", 32'(level), 0);
        check("rst_drop_cnt", 32'(drop_cnt), 0);
        check("rst_ovf", 32'(ovf), 0);
        check("rst_out_hd", 32'(out_hd), 0);
        check("rst_out_ld", 32'(out_ld), 0);
        rst       = 1'b0;
        out_ready = 1'b1;

        // Threshold and 3-cycle latency
        send(1000, 25600, 500, EXP_P1000, 1600, 1'b1);
        idle();
        check("lat_e0", 32'(out_valid), 0);
        step();
        check("lat_e1", 32'(out_valid), 0);
        step();
        check("lat_e2", 32'(out_valid), 1);
        check("thr_out_hd", 32'(out_hd), EXP_P1000);
        check("thr_out_ld", 32'(out_ld), 1600);
        drain("thr");

        // Dead zone and rounding
        send(-300, -24, 300, 0, -1, 1'b1);
        send(-300, -8, 300, 0, 0, 1'b1);
        send(300, 8, 300, 0, 1, 1'b1);
        send(301, 7, 300, EXP_301, 0, 1'b1);
        send(17, -8, 16, EXP_17, 0, 1'b1);
        send(-1000, 25600, 500, EXP_N1000, 1600, 1'b1);
        idle();
        drain("round");

        // Saturation and threshold extremes
        send(1048575, 1048575, 0, 32767, 32767, 1'b1);
        send(-1048576, -1048576, 0, -32768, -32768, 1'b1);
        send(1048575, 0, 1048575, 0, 0, 1'b1);
        send(-1048576, 0, 1048575, EXP_EDGE, 0, 1'b1);
        idle();
        drain("sat");

        // Overflow: 10 pairs into an 8-deep FIFO with no consumer
        out_ready = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            send(0, k * 16, 0, 0, k, k <= 8);
        end
        idle();
        step();
        step();
        step();
        check("ovf_level", 32'(level), 8);
        check("ovf_drop_cnt", 32'(drop_cnt), 2);
        check("ovf_flag", 32'(ovf), 1);
        out_ready = 1'b1;
        drain("ovf");
        check("ovf_sticky", 32'(ovf), 1);
        check("ovf_level_empty", 32'(level), 0);

        // Full FIFO with simultaneous push and pop
        out_ready = 1'b0;
        for (int k = 11; k <= 18; k++) begin
            send(0, k * 16, 0, 0, k, 1'b1);
        end
        idle();
        step();
        step();
        step();
        check("full_prefill_level", 32'(level), 8);
        for (int i = 0; i < 12; i++) begin
            if (i == 2) begin
                out_ready = 1'b1;
            end
            send(0, (19 + i) * 16, 0, 0, 19 + i, 1'b1);
            if (i >= 2) begin
                check("full_level_hold", 32'(level), 8);
                check("full_drop_cnt", 32'(drop_cnt), 2);
            end
        end
        idle();
        drain("full");

        // Reset mid-stream: 5 stored, 2 in flight, plus one pair in the reset cycle
        out_ready = 1'b0;
        for (int k = 31; k <= 37; k++) begin
            send(0, k * 16, 0, 0, k, 1'b0);
        end
        idle();
        check("pre_rst_level", 32'(level), 5);
        rst      = 1'b1;
        in_valid = 1'b1;
        hd_in    = 21'd5000;
        ld_in    = 21'd4000;
        thr      = 20'd0;
        step();
        rst      = 1'b0;
        in_valid = 1'b0;
        check("mid_rst_out_valid", 32'(out_valid), 0);
        check("mid_rst_level", 32'(level), 0);
        check("mid_rst_drop_cnt", 32'(drop_cnt), 0);
        check("mid_rst_ovf", 32'(ovf), 0);
        check("mid_rst_out_hd", 32'(out_hd), 0);
        check("mid_rst_out_ld", 32'(out_ld), 0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("flush_no_output", 32'(out_valid), 0);
        end
        send(-1000, 160, 500, EXP_N1000, 10, 1'b1);
        idle();
        check("post_rst_lat_e0", 32'(out_valid), 0);
        step();
        check("post_rst_lat_e1", 32'(out_valid), 0);
        step();
        check("post_rst_lat_e2", 32'(out_valid), 1);
        check("post_rst_out_ld", 32'(out_ld), 10);
        drain("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
